// File: rtl/universal_shift_register_pkg.sv
// Shared types and constants for the universal shift register.
//   shift_mode_t  : encoding of the 2-bit mode input
//   DEFAULT_WIDTH : default register width
package universal_shift_register_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SHIFT_LEFT  = 2'b00,
    SHIFT_RIGHT = 2'b01,
    ROTATE_LEFT = 2'b10,
    HOLD        = 2'b11
  } shift_mode_t;

endpackage : universal_shift_register_pkg

// File: rtl/usr_frame_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle wrap pulse.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : return count to 0 and suppress wrap (dominates inc)
//   inc        : one shift performed this cycle
//   count      : shifts completed in the current frame, 0..WIDTH-1
//   wrap       : high for one cycle after the WIDTH-th increment
module usr_frame_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // Next count and wrap pulse.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule : usr_frame_counter

// File: rtl/universal_shift_register.sv
// Parametrised shift register: left/right shift, optional rotate-left,
// parallel load, serial output and per-frame shift counter.
// Configuration macro: USR_ROTATE_EN -- when defined, mode 10 rotates left;
// otherwise mode 10 is treated as hold.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (highest priority)
//   shift_enable : qualifies a shift this cycle
//   mode         : 00 left, 01 right, 10 rotate left, 11 hold
//   data_in      : serial input bit
//   load         : parallel load strobe (beats shift)
//   load_data    : parallel load value
//   data_out     : register contents
//   serial_out   : bit that leaves on the next shift (mux of registered state)
//   shift_count  : shifts completed in the current frame
//   frame_done   : one-cycle pulse after each WIDTH-th shift
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int unsigned          WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  localparam int unsigned         CW          = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_enable,
  input  logic [1:0]       mode,
  input  logic             data_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic [CW-1:0]    shift_count,
  output logic             frame_done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             shift_c;

  // Shift datapath; shift_c marks cycles that count toward a frame.
  always_comb begin
    data_d  = data_q;
    shift_c = 1'b0;
    if (load) begin
      data_d = load_data;
    end else if (shift_enable) begin
      case (shift_mode_t'(mode))
        SHIFT_LEFT: begin
          data_d  = {data_q[WIDTH-2:0], data_in};
          shift_c = 1'b1;
        end
        SHIFT_RIGHT: begin
          data_d  = {data_in, data_q[WIDTH-1:1]};
          shift_c = 1'b1;
        end
`ifdef USR_ROTATE_EN
        ROTATE_LEFT: begin
          data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          shift_c = 1'b1;
        end
`endif
        default: begin
          data_d  = data_q;
          shift_c = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  usr_frame_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .inc   (shift_c),
    .count (shift_count),
    .wrap  (frame_done)
  );

  assign data_out = data_q;

  // Odd modes (right, hold) expose the LSB; even modes (left, rotate) the MSB.
  assign serial_out = mode[0] ? data_q[0] : data_q[WIDTH-1];

endmodule : universal_shift_register
